// File: rtl/sar_search.sv
// sar_search: successive-approximation search that recovers a comparator's a-side value MSB first.
// Ports: clk, n_rst (async active-low); start requests a search (IDLE only);
//        cmp_gt/cmp_lt/cmp_eq one-hot comparator verdict for the current trial;
//        trial drives comparator b-input; busy high in TEST; done pulses one cycle;
//        result holds recovered value; err flags a non-one-hot verdict.
module sar_search #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mask_q, mask_d, result_q, result_d, acc_nxt;
    logic             err_q, err_d, one_hot;
    assign trial   = state_q == TEST ? acc_q | mask_q : '0;
    assign busy    = state_q == TEST;
    assign done    = state_q == DONE;
    assign result  = result_q;
    assign err     = err_q;
    assign one_hot = {cmp_gt, cmp_lt, cmp_eq} inside {3'b100, 3'b010, 3'b001};
    assign acc_nxt = cmp_gt ? trial : acc_q;
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mask_d   = mask_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d   = '0;
                mask_d  = {1'b1, {(WIDTH-1){1'b0}}};
                err_d   = 1'b0;
                state_d = TEST;
            end
            TEST: if (!one_hot) begin
                err_d    = 1'b1;
                result_d = '0;
                state_d  = DONE;
            end else if (cmp_eq) begin
                result_d = trial;
                state_d  = DONE;
            end else begin
                acc_d = acc_nxt;
                // mask[0] set means the LSB was just decided: the build is complete
                if (mask_q[0]) begin
                    result_d = acc_nxt;
                    state_d  = DONE;
                end else begin
                    mask_d = mask_q >> 1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mask_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed bench for sar_search with a behavioural comparator.
module tb_sar_search;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic        cmp_gt, cmp_lt, cmp_eq;
    logic [15:0] trial, result;
    logic        busy, done, err;
    logic [15:0] target = '0;
    logic        ovr = 1'b0;
    logic        ovr_gt = 1'b0, ovr_lt = 1'b0, ovr_eq = 1'b0;
    int          total = 0, bad = 0;
    logic [15:0] seq [0:13] = '{16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h1800, 16'h1400, 16'h1200,
                                16'h1300, 16'h1280, 16'h1240, 16'h1220, 16'h1230, 16'h1238, 16'h1234};

    always #5 clk = ~clk;

    assign cmp_gt = ovr ? ovr_gt : target > trial;
    assign cmp_lt = ovr ? ovr_lt : target < trial;
    assign cmp_eq = ovr ? ovr_eq : target == trial;

    sar_search dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .trial(trial), .busy(busy), .done(done), .result(result), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [15:0] tgt, input int exp_lat, input bit do_seq, input bit poke);
        int n;
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("trial0", trial, 16'h8000);
        chk("busy1", busy, 1);
        n = 1;
        while (!done && n < 40) begin
            if (do_seq && n <= 14) chk($sformatf("trial%0d", n), trial, seq[n-1]);
            start = poke && n == 3;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", n, exp_lat);
        chk("result", result, tgt);
        chk("err0", err, 0);
        chk("busy0", busy, 0);
        chk("trial_done", trial, 0);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("result_hold", result, tgt);
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_trial", trial, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        run(16'h8000, 2, 0, 0);
        run(16'h0000, 17, 0, 0);
        run(16'hFFFF, 17, 0, 0);
        run(16'h1234, 15, 1, 1);
        // reset in compare 5 of a 0x1234 search
        target = 16'h1234;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("pre_rst_trial", trial, 16'h1800);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_trial", trial, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_err", err, 0);
        @(posedge clk); #1;
        chk("rst_hold_done", done, 0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        run(16'h00FF, 17, 0, 0);
        // non-one-hot verdict on compare 3
        target = 16'h1234;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bad_trial", trial, 16'h2000);
        ovr = 1'b1; ovr_gt = 1'b1; ovr_lt = 1'b1;
        @(posedge clk); #1;
        ovr = 1'b0; ovr_gt = 1'b0; ovr_lt = 1'b0;
        chk("bad_done", done, 1);
        chk("bad_err", err, 1);
        chk("bad_result", result, 0);
        @(posedge clk); #1;
        chk("err_hold", err, 1);
        target = 16'h8000;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_clear", err, 0);
        @(posedge clk); #1;
        chk("after_err_done", done, 1);
        chk("after_err_result", result, 16'h8000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
